// File: rtl/decode_stage.sv
// Instruction-decode stage in front of the Registers bank: aligns the bank's late read data,
// patches same-edge write-back collisions and inserts a bubble on load-use hazards.
module decode_stage #(
  parameter  int unsigned INSTR_W = 32,
  parameter  int unsigned NREGS   = 32,
  localparam int unsigned RW      = $clog2(NREGS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               if_valid,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic [INSTR_W-1:0] if_pc,
  output logic               if_ready,
  input  logic               flush,
  input  logic               ex_stall,
  output logic [RW-1:0]      addra,
  output logic [RW-1:0]      addrb,
  input  logic [INSTR_W-1:0] dataa,
  input  logic [INSTR_W-1:0] datab,
  input  logic               enc,
  input  logic [RW-1:0]      addrc,
  input  logic [INSTR_W-1:0] datac,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_pc,
  output logic [5:0]         id_opcode,
  output logic [5:0]         id_funct,
  output logic [RW-1:0]      id_rs,
  output logic [RW-1:0]      id_rt,
  output logic [RW-1:0]      id_dest,
  output logic               id_reg_write,
  output logic               id_mem_read,
  output logic               id_mem_write,
  output logic               id_branch,
  output logic [INSTR_W-1:0] id_imm,
  output logic [INSTR_W-1:0] id_a,
  output logic [INSTR_W-1:0] id_b
);

  localparam int unsigned OPW   = 6;
  localparam int unsigned IMM_W = 16;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic [RW-1:0] dest;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          branch;
    logic          uses_rt;
  } ctrl_t;

  logic               v;
  logic [INSTR_W-1:0] instr;
  logic [INSTR_W-1:0] pc;
  logic [INSTR_W-1:0] byp_a;
  logic [INSTR_W-1:0] byp_b;
  logic               byp_a_vld;
  logic               byp_b_vld;
  logic               ld_pend;
  logic [RW-1:0]      ld_rt;

  logic [OPW-1:0]     opcode;
  logic [RW-1:0]      rs;
  logic [RW-1:0]      rt;
  logic [RW-1:0]      rd;
  ctrl_t              ctrl;
  logic               load_use;
  logic               hold;
  logic               hit_a;
  logic               hit_b;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];

  // Control decode; unknown opcodes fall through as a nop
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.dest      = rd;
        ctrl.reg_write = 1'b1;
        ctrl.uses_rt   = 1'b1;
      end
      OP_LW: begin
        ctrl.dest      = rt;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch    = 1'b1;
        ctrl.uses_rt   = 1'b1;
      end
      OP_ADDI: begin
        ctrl.dest      = rt;
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Load-use hazard against the load that left decode in the last unstalled cycle
  assign load_use = v && ld_pend && (ld_rt != '0) &&
                    ((rs == ld_rt) || (ctrl.uses_rt && (rt == ld_rt)));
  assign hold     = v && (ex_stall || load_use);
  assign if_ready = !reset && !hold;

  // While holding, re-read the held operands so write-backs during the hold are picked up
  assign addra = hold ? rs : if_instr[25:21];
  assign addrb = hold ? rt : if_instr[20:16];

  assign hit_a = enc && (addrc == addra) && (addrc != '0);
  assign hit_b = enc && (addrc == addrb) && (addrc != '0);

  assign id_valid     = v && !load_use;
  assign id_pc        = pc;
  assign id_opcode    = opcode;
  assign id_funct     = instr[5:0];
  assign id_rs        = rs;
  assign id_rt        = rt;
  assign id_dest      = ctrl.dest;
  assign id_reg_write = v && ctrl.reg_write;
  assign id_mem_read  = v && ctrl.mem_read;
  assign id_mem_write = v && ctrl.mem_write;
  assign id_branch    = v && ctrl.branch;
  assign id_imm       = {{(INSTR_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};

  // Operands: r0 reads zero, a same-edge write-back overrides the stale bank value
  always_comb begin
    id_a = dataa;
    id_b = datab;
    if (rs == '0)     id_a = '0;
    else if (byp_a_vld) id_a = byp_a;
    if (rt == '0)     id_b = '0;
    else if (byp_b_vld) id_b = byp_b;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v         <= 1'b0;
      instr     <= '0;
      pc        <= '0;
      byp_a     <= '0;
      byp_b     <= '0;
      byp_a_vld <= 1'b0;
      byp_b_vld <= 1'b0;
      ld_pend   <= 1'b0;
      ld_rt     <= '0;
    end else begin
      byp_a_vld <= hit_a;
      byp_b_vld <= hit_b;
      if (hit_a) byp_a <= datac;
      if (hit_b) byp_b <= datac;
      if (flush) begin
        v         <= 1'b0;
        ld_pend   <= 1'b0;
        byp_a_vld <= 1'b0;
        byp_b_vld <= 1'b0;
      end else begin
        if (!ex_stall) begin
          ld_pend <= id_valid && id_mem_read && (rt != '0);
          ld_rt   <= rt;
        end
        if (!hold) begin
          v     <= if_valid;
          instr <= if_instr;
          pc    <= if_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations, then random traffic
// checked every cycle against an architectural register-file and issue model.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        flush;
  logic        ex_stall;
  logic [4:0]  addra;
  logic [4:0]  addrb;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        enc;
  logic [4:0]  addrc;
  logic [31:0] datac;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_dest;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_branch;
  logic [31:0] id_imm;
  logic [31:0] id_a;
  logic [31:0] id_b;

  decode_stage #(.INSTR_W(32), .NREGS(32)) dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .flush(flush), .ex_stall(ex_stall),
    .addra(addra), .addrb(addrb), .dataa(dataa), .datab(datab),
    .enc(enc), .addrc(addrc), .datac(datac),
    .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_imm(id_imm), .id_a(id_a), .id_b(id_b)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural register file (also serves as the bank contents)
  logic [31:0] regs [32];

  // Model: instruction sitting in decode, and the destination of a load issued last unstalled cycle
  logic        m_v;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_prev_load;
  logic [4:0]  m_prev_load_rt;
  logic        e_ready;
  logic [31:0] na;
  logic [31:0] nb;
  logic [31:0] p_mark;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void decode_ref(input logic [31:0] ins, output logic [4:0] dest,
                                     output logic rw, output logic mr, output logic mw,
                                     output logic br, output logic reads_rt);
    dest = 5'd0; rw = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0; reads_rt = 1'b0;
    case (ins[31:26])
      6'h00: begin dest = ins[15:11]; rw = 1'b1; reads_rt = 1'b1; end
      6'h23: begin dest = ins[20:16]; rw = 1'b1; mr = 1'b1; end
      6'h2B: begin mw = 1'b1; reads_rt = 1'b1; end
      6'h04: begin br = 1'b1; reads_rt = 1'b1; end
      6'h08: begin dest = ins[20:16]; rw = 1'b1; end
      default: ;
    endcase
  endfunction

  // One clock: check at the falling edge, advance model and bank, return 1 time unit after the rising edge
  task automatic cycle();
    logic [4:0] rs, rt, dest;
    logic rw, mr, mw, br, reads_rt, stalled_on_load, issue_ok, held;
    @(negedge clock);
    rs = m_instr[25:21];
    rt = m_instr[20:16];
    decode_ref(m_instr, dest, rw, mr, mw, br, reads_rt);
    stalled_on_load = m_v && m_prev_load && (m_prev_load_rt != 5'd0) &&
                      (rs == m_prev_load_rt || (reads_rt && rt == m_prev_load_rt));
    issue_ok = m_v && !stalled_on_load;
    held     = m_v && (ex_stall || stalled_on_load);
    e_ready  = !reset && !held;
    chk("id_valid", 32'(id_valid), 32'(issue_ok));
    chk("if_ready", 32'(if_ready), 32'(e_ready));
    if (!reset) begin
      chk("addra", 32'(addra), 32'(held ? rs : if_instr[25:21]));
      chk("addrb", 32'(addrb), 32'(held ? rt : if_instr[20:16]));
    end
    if (issue_ok) begin
      chk("id_pc", id_pc, m_pc);
      chk("id_opcode", 32'(id_opcode), 32'(m_instr[31:26]));
      chk("id_funct", 32'(id_funct), 32'(m_instr[5:0]));
      chk("id_rs", 32'(id_rs), 32'(rs));
      chk("id_rt", 32'(id_rt), 32'(rt));
      chk("id_dest", 32'(id_dest), 32'(dest));
      chk("id_reg_write", 32'(id_reg_write), 32'(rw));
      chk("id_mem_read", 32'(id_mem_read), 32'(mr));
      chk("id_mem_write", 32'(id_mem_write), 32'(mw));
      chk("id_branch", 32'(id_branch), 32'(br));
      chk("id_imm", id_imm, 32'($signed(m_instr[15:0])));
      chk("id_a", id_a, (rs == 5'd0) ? 32'd0 : regs[rs]);
      chk("id_b", id_b, (rt == 5'd0) ? 32'd0 : regs[rt]);
    end
    // Bank read returns pre-write contents; write-back lands at the same edge
    na = regs[addra];
    nb = regs[addrb];
    if (enc) regs[addrc] = datac;
    if (reset) begin
      m_v = 1'b0; m_instr = '0; m_pc = '0; m_prev_load = 1'b0; m_prev_load_rt = '0;
    end else if (flush) begin
      m_v = 1'b0; m_prev_load = 1'b0;
    end else begin
      if (!ex_stall) begin
        m_prev_load    = issue_ok && mr && (rt != 5'd0);
        m_prev_load_rt = rt;
      end
      if (!held) begin
        m_v = if_valid; m_instr = if_instr; m_pc = if_pc;
      end
    end
    @(posedge clock);
    #1;
    dataa = na;
    datab = nb;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic st, input logic fl,
                       input logic en, input logic [4:0] ac, input logic [31:0] dc);
    if_valid = v; if_instr = ins; if_pc = if_pc + 32'd4;
    ex_stall = st; flush = fl; enc = en; addrc = ac; datac = dc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 5))
      0: op = 6'h00;
      1: op = 6'h23;
      2: op = 6'h2B;
      3: op = 6'h04;
      4: op = 6'h08;
      default: op = 6'h3F;
    endcase
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom), 6'($urandom)};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 | 32'(i);
    regs[0] = 32'hBAD0_0000;
    reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = 32'h0000_0FFC;
    flush = 1'b0; ex_stall = 1'b0; enc = 1'b0; addrc = '0; datac = '0;
    dataa = '0; datab = '0;
    m_v = 1'b0; m_instr = '0; m_pc = '0; m_prev_load = 1'b0; m_prev_load_rt = '0;
    e_ready = 1'b0; p_mark = '0;

    @(posedge clock);
    #3;
    chk("rst if_ready", 32'(if_ready), 32'd0);
    chk("rst id_valid", 32'(id_valid), 32'd0);
    chk("rst id_pc", id_pc, 32'd0);
    chk("rst id_reg_write", 32'(id_reg_write), 32'd0);
    chk("rst id_dest", 32'(id_dest), 32'd0);
    chk("rst id_imm", id_imm, 32'd0);
    chk("rst id_a", id_a, 32'd0);
    chk("rst id_b", id_b, 32'd0);
    cycle();
    reset = 1'b0;

    // addi r1,r0,5
    drive(1'b1, 32'h2001_0005, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("addi id_valid", 32'(id_valid), 32'd1);
    chk("addi id_dest", 32'(id_dest), 32'd1);
    chk("addi id_imm", id_imm, 32'd5);
    chk("addi id_reg_write", 32'(id_reg_write), 32'd1);
    cycle();

    // add r4,r3,r3 with write-back to r3 at the accept edge
    drive(1'b1, 32'h0063_2020, 1'b0, 1'b0, 1'b1, 5'd3, 32'hDEAD_0001);
    cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("wb id_a", id_a, 32'hDEAD_0001);
    chk("wb id_b", id_b, 32'hDEAD_0001);
    cycle();

    // lw r2,0(r1) then add r5,r2,r0
    drive(1'b1, 32'h8C22_0000, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle();
    drive(1'b1, 32'h0040_2820, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    p_mark = if_pc;
    cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("lu bubble id_valid", 32'(id_valid), 32'd0);
    chk("lu bubble if_ready", 32'(if_ready), 32'd0);
    cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("lu add id_valid", 32'(id_valid), 32'd1);
    chk("lu add id_pc", id_pc, p_mark);
    chk("lu add id_rs", 32'(id_rs), 32'd2);
    cycle();

    // add r6,r4,r0 held by a 3-cycle stall, r4 <- 7 during the stall
    drive(1'b1, 32'h0080_3020, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    p_mark = if_pc;
    cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd4, 32'd7);
    cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("stall id_a", id_a, 32'd7);
    chk("stall id_pc", id_pc, p_mark);
    chk("stall id_valid", 32'(id_valid), 32'd1);
    cycle();

    // lw r7 issues, then flush+stall must clear the pending load
    drive(1'b1, 32'h8C07_0000, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle();
    drive(1'b1, 32'h2009_0001, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle();
    drive(1'b1, 32'h00E7_4020, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    cycle();
    drive(1'b1, 32'h00E7_4020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("flush id_valid", 32'(id_valid), 32'd0);
    cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("flush no load-use", 32'(id_valid), 32'd1);
    cycle();

    // add r1,r0,r0 with a write-back to r0
    drive(1'b1, 32'h0000_0820, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("r0 id_a", id_a, 32'd0);
    chk("r0 id_b", id_b, 32'd0);
    chk("r0 id_dest", 32'(id_dest), 32'd1);
    cycle();

    // Random traffic; fetch keeps presenting an instruction until it is taken or flushed
    for (int i = 0; i < 3000; i++) begin
      if (!if_valid || e_ready || flush) begin
        if_valid = ($urandom_range(0, 4) != 0);
        if_instr = rand_instr();
        if_pc    = if_pc + 32'd4;
      end
      ex_stall = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 24) == 0);
      reset    = ($urandom_range(0, 399) == 0);
      enc      = ($urandom_range(0, 1) == 1);
      addrc    = 5'($urandom_range(0, 7));
      datac    = $urandom();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode pipeline stage that sits directly upstream of the `Registers` bank. It accepts one instruction per cycle from fetch and drives the bank's read addresses. It aligns the bank's one-cycle-late read data with the latched instruction, patches same-edge write-back collisions and inserts a one-cycle bubble on load-use hazards. It hands a fully decoded, registered bundle to the execute stage.

## Interface
Parameters:
- `INSTR_W`, 32: instruction and PC width.
- `NREGS`, 32: architectural registers; addresses are 5 bits.

Ports:
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high; sampled on the rising edge of `clock`.
- `if_valid`  in  1: fetch presents an instruction.
- `if_instr`  in  32: instruction word.
- `if_pc`  in  32: instruction PC.
- `if_ready`  out  1: decode accepts `if_instr` at this edge; equals `!reset && !hold`.
- `flush`  in  1: kill the held and incoming instruction (branch redirect).
- `ex_stall`  in  1: execute cannot accept this cycle.
- `addra`, `addrb`  out  5: read addresses to `Registers`.
- `dataa`, `datab`  in  32: bank read data, registered inside `Registers`.
- `enc`, `addrc`, `datac`  in  1/5/32: the write-back port, observed in parallel with the bank.
- `id_valid`  out  1: bundle valid for execute.
- `id_pc`  out  32
- `id_opcode`, `id_funct`  out  6
- `id_rs`, `id_rt`  out  5
- `id_dest`  out  5
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch`  out  1
- `id_imm`  out  32
- `id_a`, `id_b`  out  32

## Operation
- State held in decode:
  - `v`: slot valid.
  - Instruction and PC registers.
  - Bypass registers `byp_a` and `byp_b`, each with a valid flag.
  - Load tracker `ld_pend` plus `ld_rt`.
- Read addresses:
  - While decode accepts, `addra` = `if_instr[25:21]` and `addrb` = `if_instr[20:16]`.
  - While decode holds, both addresses are taken from the held instruction's rs and rt.
- Bypass, evaluated at every edge and for each port: `byp_x` ← `datac`, valid ← 1 when `enc && addrc == addrx && addrc != 0`; otherwise valid ← 0.
- Operand outputs:
  - `id_a` = 0 if `id_rs == 0`; else `byp_a` if its valid flag is set; else `dataa`.
  - `id_b` is formed the same way from `id_rt`, `byp_b` and `datab`.
- Control decode by opcode:
  - `000000` (R-type): dest = rd, reg_write = 1, uses rt.
  - `100011` (lw): dest = rt, reg_write = 1, mem_read = 1.
  - `101011` (sw): dest = 0, mem_write = 1, uses rt.
  - `000100` (beq): dest = 0, branch = 1, uses rt.
  - `001000` (addi): dest = rt, reg_write = 1.
  - Any other opcode: all control outputs 0, dest = 0; the instruction passes through as a nop.
- Immediate: `id_imm` = `instr[15:0]` sign-extended to 32 bits.
- `id_funct` = `instr[5:0]`.
- Load-use hazard:
  - `load_use` = `v && ld_pend && ld_rt != 0 && (rs == ld_rt || (uses_rt && rt == ld_rt))`.
  - `id_valid` = `v && !load_use`.
  - `hold` = `v && (ex_stall || load_use)`.
- Load tracker update:
  - If `ex_stall` = 1: `ld_pend` and `ld_rt` hold.
  - Otherwise: `ld_pend` ← `id_valid && id_mem_read && rt != 0`, and `ld_rt` ← rt.
- Slot update:
  - Accept (`!hold`): `v` ← `if_valid`, and the instruction and PC are latched.
  - Hold: the slot is unchanged.
- Priority: `reset` > `flush` > hold > accept.
- `flush`: `v`, `ld_pend` and both bypass valid flags ← 0. The instruction presented by fetch in the same cycle is discarded.

## Timing
- Reset:
  - `v`, `ld_pend` and both bypass valid flags = 0.
  - Instruction and PC registers = 0.
  - Every `id_*` output = 0, including `id_a` and `id_b`, since rs = rt = 0.
  - `if_ready` = 0 during the reset cycle.
- Latency: an instruction accepted at edge N is presented on `id_*` during cycle N+1, with operands valid in that same cycle.
- Throughput: 1 instruction per cycle with no hazards.
- Write-back at the same edge as the bank read: the bank returns the stale value, and `id_x` must return `datac`.
- Write-back while decode holds: captured at the next edge through re-read plus bypass; the value seen in the following cycle is current.
- A write-back to r0 never changes `id_a` or `id_b`.
- Load-use: exactly 1 bubble (`id_valid` = 0 for one cycle). With `ex_stall` asserted, the bubble lasts for the duration of the stall plus 1 cycle.
- `flush` together with `ex_stall`: `flush` wins; `id_valid` = 0 in the next cycle.

## Test plan
- Reset, then `addi r1,r0,5` with `if_valid` = 1 → next cycle: `id_valid` = 1, `id_dest` = 1, `id_imm` = 5, `id_reg_write` = 1.
- Write-back `enc` = 1, `addrc` = 3, `datac` = 0xDEAD0001 at the same edge that `add r4,r3,r3` is accepted → `id_a` = `id_b` = 0xDEAD0001.
- `lw r2,0(r1)` followed by `add r5,r2,r0`:
  - Cycle after the lw issues: `id_valid` = 0 and `if_ready` = 0.
  - One cycle later: add is presented.
- `ex_stall` = 1 for 3 cycles with a write-back to the held rs (value 7) during the stall → `id_a` = 7 once the stall releases; the slot contents are unchanged.
- `flush` = 1 alongside `if_valid` = 1 and `ex_stall` = 1 → next cycle `id_valid` = 0 and `ld_pend` = 0.
- `enc` = 1, `addrc` = 0, `datac` = 0xFFFFFFFF while `add r1,r0,r0` is read → `id_a` = `id_b` = 0.
